axi4_stream_downsizer: RTL and testbench
========================================

Name: axi4_stream_downsizer

Overview:
Downstream neighbour of the single-clock store-and-forward packet FIFO. Consumes its wide AXI4-Stream output and re-emits each beat as RATIO narrower sub-words, LSB sub-word first, for a narrow sink such as a serializer or a narrow MAC.
- Null sub-words are skipped: all tkeep bits zero.
- Packet boundaries and sideband fields are preserved.
- Full backpressure in both directions.

Parameters:
- DATA_WIDTH_IN, 64, input tdata width in bits. Must be a multiple of 8*RATIO.
- RATIO, 4, sub-words per input beat. Power of two, ≥2.
- USER_WIDTH, 1, tuser width. Copied unchanged to every sub-word.
- DEST_WIDTH, 1, tdest width. Copied unchanged to every sub-word.
- ID_WIDTH, 1, tid width. Copied unchanged to every sub-word.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- pkt_i  axi4_stream_if.slave  DATA_WIDTH_IN data, DATA_WIDTH_IN/8 tstrb/tkeep  wide input stream (from FIFO pkt_o).
- pkt_o  axi4_stream_if.master  DATA_WIDTH_IN/RATIO data, DATA_WIDTH_IN/(8*RATIO) tstrb/tkeep  narrow output stream.

Behaviour:
- Derived widths: OUT_W = DATA_WIDTH_IN/RATIO, OUT_B = OUT_W/8, IDX_W = $clog2(RATIO).
- One holding register stores the accepted beat: data, strb, keep, last, user, dest, id.
- The block also holds a valid flag, a sub-word index idx[IDX_W-1:0] and a last-index register lidx.
- Sub-word k of the held beat is bits [k*OUT_W +: OUT_W], with matching strb/keep slices.
- Capture on pkt_i.tvalid && pkt_i.tready:
  - Load the holding register and set valid.
  - idx <= index of the lowest sub-word with nonzero keep.
  - lidx <= index of the highest sub-word with nonzero keep.
  - If all keep bits are zero: idx = lidx = 0, and the beat emits exactly one sub-word with tkeep = 0.
- Output:
  - pkt_o.tvalid = valid.
  - pkt_o.tdata/tstrb/tkeep = sub-word idx.
  - pkt_o.tuser/tdest/tid = held values.
  - pkt_o.tlast = held last && (idx == lidx).
- Advance on pkt_o handshake:
  - If idx == lidx, the beat is done.
  - Otherwise idx <= next index > idx with nonzero keep.
  - Sub-words in the middle of a beat with zero keep are skipped and cost no output cycle.
- Input ready: pkt_i.tready = !valid || (pkt_o.tready && idx == lidx). This gives back-to-back beats with no bubble.
- Done with a simultaneous new capture: the new beat loads and valid stays 1. Done without a capture: valid <= 0.
- Latency: 1 cycle from input handshake to first pkt_o.tvalid.
- Throughput: one sub-word per cycle while pkt_o.tready = 1.
- pkt_o signals must not change while pkt_o.tvalid && !pkt_o.tready (AXI stability).
- No state machine beyond valid/idx. No packet-level state is held, so the block needs no error handling for missing tlast.
- Reset (synchronous, rst_i sampled on clk_i edge):
  - valid = 0, idx = 0, lidx = 0, holding register = 0.
  - pkt_o.tvalid = 0 and pkt_i.tready = 1 on the first cycle after reset.
  - Reset mid-beat discards the remaining sub-words silently.

Decomposition:
- Shared package axi4_stream_pkg holds:
  - function first_set_idx(keep, RATIO)
  - function last_set_idx(keep, RATIO), which returns 0 when keep is all zero
  - function next_set_idx(keep, idx)
  - localparam helpers for OUT_W, OUT_B and IDX_W.
- No sub-module. The holding register and index logic stay inline, about 150–200 lines.

Test Plan:
- Width conversion: DATA_WIDTH_IN=64, RATIO=4, one beat tdata=0x4444_3333_2222_1111, tkeep=0xFF, tlast=1, pkt_o.tready=1 → output 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles. tlast only on 0x4444. pkt_i.tready low for the middle 3 cycles.
- Trailing null sub-words: tkeep=0x0F, tlast=1 → 2 sub-words, 0x1111 then 0x2222 with tlast=1. Next beat accepted in the same cycle as 0x2222.
- Mid-beat null sub-word: tkeep=0xC3 → sub-words 0 and 3 only. Two output cycles, sub-word 1 and 2 data never appear.
- All-zero keep: tkeep=0x00, tlast=1 → exactly one sub-word with tkeep=0, tlast=1.
- Backpressure: 3-beat packet, random pkt_o.tready at 50% → output held stable while stalled. Scoreboard shows 12 sub-words in order, one tlast. tuser/tid/tdest are constant per beat.
- Reset mid-beat: assert rst_i after sub-word 1 emitted → next cycle pkt_o.tvalid=0, pkt_i.tready=1. A new beat is then output from sub-word 0.

Source files
------------

// File: rtl/axi4_stream_pkg.sv
// Shared helpers for the AXI4-Stream width converters.
// Contents:
//   - width helpers that derive the narrow-side widths from the wide width and ratio
//   - sub-word search functions; each one takes a per-sub-word "has any keep bit" mask
//     (bit k set when sub-word k carries at least one kept byte)
// No ports. This file is a package.
package axi4_stream_pkg;

    // Upper bound on RATIO that the mask-based search functions support.
    localparam int MAX_RATIO = 64;

    function automatic int calc_out_w(input int data_width_in, input int ratio);
        return data_width_in / ratio;
    endfunction

    function automatic int calc_out_b(input int data_width_in, input int ratio);
        return data_width_in / (8 * ratio);
    endfunction

    function automatic int calc_idx_w(input int ratio);
        return $clog2(ratio);
    endfunction

    // Index of the lowest sub-word with keep set; 0 when none is set.
    function automatic int first_set_idx(input logic [MAX_RATIO-1:0] mask, input int ratio);
        int r;
        r = 0;
        for (int k = MAX_RATIO - 1; k >= 0; k--) begin
            if (k < ratio && mask[k]) r = k;
        end
        return r;
    endfunction

    // Index of the highest sub-word with keep set; 0 when none is set.
    function automatic int last_set_idx(input logic [MAX_RATIO-1:0] mask, input int ratio);
        int r;
        r = 0;
        for (int k = 0; k < MAX_RATIO; k++) begin
            if (k < ratio && mask[k]) r = k;
        end
        return r;
    endfunction

    // Lowest index above idx with keep set; idx itself when there is none.
    function automatic int next_set_idx(input logic [MAX_RATIO-1:0] mask, input int idx,
                                        input int ratio);
        int r;
        r = idx;
        for (int k = MAX_RATIO - 1; k >= 0; k--) begin
            if (k > idx && k < ratio && mask[k]) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle.
// Signals: tvalid, tready, tdata[DATA_W], tstrb/tkeep[DATA_W/8], tlast, tuser[USER_W],
//          tdest[DEST_W], tid[ID_W].
// Modports: master drives everything except tready; slave drives only tready.
interface axi4_stream_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1,
    parameter int DEST_W = 1,
    parameter int ID_W   = 1
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser;
    logic [DEST_W-1:0]     tdest;
    logic [ID_W-1:0]       tid;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                    input  tready);
    modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                    output tready);
endinterface

// File: rtl/axi4_stream_downsizer.sv
// AXI4-Stream downsizer: splits each wide beat into RATIO narrow sub-words, LSB first.
// Sub-words whose keep bits are all zero are skipped. The exception is a beat with no
// kept bytes at all, which still emits one sub-word with tkeep = 0 so that its tlast
// and sideband fields are not lost.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   pkt_i  - wide slave stream  (DATA_WIDTH_IN bits)
//   pkt_o  - narrow master stream (DATA_WIDTH_IN/RATIO bits)
module axi4_stream_downsizer
    import axi4_stream_pkg::*;
#(
    parameter int DATA_WIDTH_IN = 64,
    parameter int RATIO         = 4,
    parameter int USER_WIDTH    = 1,
    parameter int DEST_WIDTH    = 1,
    parameter int ID_WIDTH      = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);
    localparam int IN_B  = DATA_WIDTH_IN / 8;
    localparam int OUT_W = calc_out_w(DATA_WIDTH_IN, RATIO);
    localparam int OUT_B = calc_out_b(DATA_WIDTH_IN, RATIO);
    localparam int IDX_W = calc_idx_w(RATIO);

    logic                     valid_q, valid_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         lidx_q, lidx_d;
    logic [DATA_WIDTH_IN-1:0] data_q, data_d;
    logic [IN_B-1:0]          strb_q, strb_d;
    logic [IN_B-1:0]          keep_q, keep_d;
    logic                     last_q, last_d;
    logic [USER_WIDTH-1:0]    user_q, user_d;
    logic [DEST_WIDTH-1:0]    dest_q, dest_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;

    logic [RATIO-1:0]         in_mask;
    logic [RATIO-1:0]         held_mask;
    logic                     beat_done;
    logic                     in_ready;
    logic                     in_fire;
    logic                     out_fire;
    int                       sel_bit;
    int                       sel_byte;

    // Collapse keep to one bit per sub-word for both the incoming and the held beat.
    always_comb begin
        in_mask   = '0;
        held_mask = '0;
        for (int k = 0; k < RATIO; k++) begin
            in_mask[k]   = |pkt_i.tkeep[k*OUT_B +: OUT_B];
            held_mask[k] = |keep_q[k*OUT_B +: OUT_B];
        end
    end

    // A beat is on its final sub-word once idx has reached the highest kept sub-word;
    // accepting the next beat then keeps the output stream free of bubbles.
    assign beat_done = (idx_q == lidx_q);
    assign in_ready  = !valid_q || (pkt_o.tready && beat_done);
    assign in_fire   = pkt_i.tvalid && in_ready;
    assign out_fire  = valid_q && pkt_o.tready;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        lidx_d  = lidx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        dest_d  = dest_q;
        id_d    = id_q;

        if (out_fire) begin
            if (beat_done) begin
                valid_d = 1'b0;
            end else begin
                idx_d = IDX_W'(next_set_idx(MAX_RATIO'(held_mask), int'(idx_q), RATIO));
            end
        end

        // A capture overrides the retire above so a finishing beat hands straight over.
        if (in_fire) begin
            valid_d = 1'b1;
            idx_d   = IDX_W'(first_set_idx(MAX_RATIO'(in_mask), RATIO));
            lidx_d  = IDX_W'(last_set_idx(MAX_RATIO'(in_mask), RATIO));
            data_d  = pkt_i.tdata;
            strb_d  = pkt_i.tstrb;
            keep_d  = pkt_i.tkeep;
            last_d  = pkt_i.tlast;
            user_d  = pkt_i.tuser;
            dest_d  = pkt_i.tdest;
            id_d    = pkt_i.tid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            lidx_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            dest_q  <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            lidx_q  <= lidx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
            dest_q  <= dest_d;
            id_q    <= id_d;
        end
    end

    // Outputs come only from registers, so they hold still while the sink stalls.
    always_comb begin
        sel_bit  = int'(idx_q) * OUT_W;
        sel_byte = int'(idx_q) * OUT_B;
    end

    assign pkt_i.tready = in_ready;
    assign pkt_o.tvalid = valid_q;
    assign pkt_o.tdata  = data_q[sel_bit +: OUT_W];
    assign pkt_o.tstrb  = strb_q[sel_byte +: OUT_B];
    assign pkt_o.tkeep  = keep_q[sel_byte +: OUT_B];
    assign pkt_o.tlast  = last_q && beat_done;
    assign pkt_o.tuser  = user_q;
    assign pkt_o.tdest  = dest_q;
    assign pkt_o.tid    = id_q;

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
module tb_axi4_stream_downsizer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk_i = ~clk_i;

    axi4_stream_if #(.DATA_W(64)) in_if ();
    axi4_stream_if #(.DATA_W(16)) out_if ();

    axi4_stream_downsizer #(
        .DATA_WIDTH_IN(64), .RATIO(4), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .pkt_i(in_if),
        .pkt_o(out_if)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input logic u, input logic de, input logic i);
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tstrb  = k;
        in_if.tlast  = l;
        in_if.tuser  = u;
        in_if.tdest  = de;
        in_if.tid    = i;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (out_if.tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tvalid: got %b expected 0", out_if.tvalid);
        end
        tests_run++;
        if (in_if.tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b expected 1", in_if.tready);
        end
        tests_run++;
        if (out_if.tdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_tdata: got %h expected 0000", out_if.tdata);
        end
    endtask

    task automatic test_width();
        logic [15:0] want [4];
        want = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        out_if.tready = 1'b1;
        drive_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_if.tvalid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_if.tvalid !== 1'b1 || out_if.tdata !== want[k]) begin
                tests_failed++;
                $display("FAIL width_data[%0d]: got v=%b %h expected v=1 %h",
                         k, out_if.tvalid, out_if.tdata, want[k]);
            end
            tests_run++;
            if (out_if.tlast !== (k == 3)) begin
                tests_failed++;
                $display("FAIL width_last[%0d]: got %b expected %b", k, out_if.tlast, (k == 3));
            end
            tests_run++;
            if (in_if.tready !== (k == 3)) begin
                tests_failed++;
                $display("FAIL width_ready[%0d]: got %b expected %b", k, in_if.tready, (k == 3));
            end
            tick();
        end
        tests_run++;
        if (out_if.tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL width_idle: got tvalid %b expected 0", out_if.tvalid);
        end
    endtask

    task automatic test_trailing();
        logic [15:0] want [4];
        want = '{16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        out_if.tready = 1'b1;
        drive_beat(64'h4444_3333_2222_1111, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (out_if.tdata !== 16'h1111 || out_if.tlast !== 1'b0 || in_if.tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL trail_first: got %h last=%b rdy=%b expected 1111 last=0 rdy=0",
                     out_if.tdata, out_if.tlast, in_if.tready);
        end
        tick();
        tests_run++;
        if (out_if.tdata !== 16'h2222 || out_if.tlast !== 1'b1 || in_if.tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL trail_second: got %h last=%b rdy=%b expected 2222 last=1 rdy=1",
                     out_if.tdata, out_if.tlast, in_if.tready);
        end
        tick();
        in_if.tvalid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_if.tvalid !== 1'b1 || out_if.tdata !== want[k] || out_if.tlast !== 1'b0) begin
                tests_failed++;
                $display("FAIL trail_next[%0d]: got v=%b %h last=%b expected v=1 %h last=0",
                         k, out_if.tvalid, out_if.tdata, out_if.tlast, want[k]);
            end
            tick();
        end
        tests_run++;
        if (out_if.tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL trail_idle: got tvalid %b expected 0", out_if.tvalid);
        end
    endtask

    task automatic test_mid_null();
        out_if.tready = 1'b1;
        drive_beat(64'h4444_3333_2222_1111, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_if.tvalid = 1'b0;
        #1;
        tests_run++;
        if (out_if.tdata !== 16'h1111 || out_if.tkeep !== 2'b11 || out_if.tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL midnull_sw0: got %h keep=%b last=%b expected 1111 keep=11 last=0",
                     out_if.tdata, out_if.tkeep, out_if.tlast);
        end
        tick();
        tests_run++;
        if (out_if.tdata !== 16'h4444 || out_if.tkeep !== 2'b11 || out_if.tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL midnull_sw3: got %h keep=%b last=%b expected 4444 keep=11 last=1",
                     out_if.tdata, out_if.tkeep, out_if.tlast);
        end
        tick();
        tests_run++;
        if (out_if.tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midnull_idle: got tvalid %b expected 0", out_if.tvalid);
        end
    endtask

    task automatic test_all_zero_keep();
        out_if.tready = 1'b1;
        drive_beat(64'h4444_3333_2222_1111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_if.tvalid = 1'b0;
        #1;
        tests_run++;
        if (out_if.tvalid !== 1'b1 || out_if.tkeep !== 2'b00 || out_if.tlast !== 1'b1 ||
            out_if.tdata !== 16'h1111) begin
            tests_failed++;
            $display("FAIL zero_keep: got v=%b %h keep=%b last=%b expected v=1 1111 keep=00 last=1",
                     out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tlast);
        end
        tick();
        tests_run++;
        if (out_if.tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_keep_idle: got tvalid %b expected 0", out_if.tvalid);
        end
    endtask

    task automatic test_backpressure();
        int          n;
        int          lasts;
        int          b;
        int          eb;
        int          ek;
        logic        in_fire;
        logic        stall;
        logic [21:0] cur;
        logic [21:0] prev;
        logic [21:0] want;
        logic [63:0] d;
        n = 0; lasts = 0; b = 0; in_fire = 1'b0; stall = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 200 && n < 12; cyc++) begin
            if (in_fire) b++;
            if (b < 3) begin
                for (int k = 0; k < 4; k++) d[k*16 +: 16] = {4'(b + 1), 4'h0, 8'(k)};
                drive_beat(d, 8'hFF, (b == 2), b[0], ~b[0], b[1]);
            end else begin
                in_if.tvalid = 1'b0;
            end
            out_if.tready = 1'($urandom_range(0, 1));
            #1;
            cur = {out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser, out_if.tdest, out_if.tid};
            if (stall) begin
                tests_run++;
                if (out_if.tvalid !== 1'b1 || cur !== prev) begin
                    tests_failed++;
                    $display("FAIL bp_stable: got v=%b %h expected v=1 %h", out_if.tvalid, cur, prev);
                end
            end
            if (out_if.tvalid && out_if.tready) begin
                eb = n / 4;
                ek = n % 4;
                want = {4'(eb + 1), 4'h0, 8'(ek), 2'b11, (n == 11), 1'(eb % 2), 1'(~(eb % 2)),
                        1'((eb / 2) % 2)};
                tests_run++;
                if (cur !== want) begin
                    tests_failed++;
                    $display("FAIL bp_word[%0d]: got %h expected %h", n, cur, want);
                end
                if (out_if.tlast) lasts++;
                n++;
            end
            stall   = out_if.tvalid && !out_if.tready;
            prev    = cur;
            in_fire = in_if.tvalid && in_if.tready;
            tick();
        end
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        tests_run++;
        if (n != 12) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d sub-words expected 12", n);
        end
        tests_run++;
        if (lasts != 1) begin
            tests_failed++;
            $display("FAIL bp_tlast_count: got %0d expected 1", lasts);
        end
        tick();
    endtask

    task automatic test_reset_mid_beat();
        out_if.tready = 1'b1;
        drive_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_if.tvalid = 1'b0;
        #1;
        tick();
        tests_run++;
        if (out_if.tdata !== 16'h2222) begin
            tests_failed++;
            $display("FAIL rstmid_sw1: got %h expected 2222", out_if.tdata);
        end
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_state: got v=%b rdy=%b expected v=0 rdy=1",
                     out_if.tvalid, in_if.tready);
        end
        drive_beat(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_if.tvalid = 1'b0;
        #1;
        tests_run++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== 16'h5555) begin
            tests_failed++;
            $display("FAIL rstmid_new_sw0: got v=%b %h expected v=1 5555",
                     out_if.tvalid, out_if.tdata);
        end
        repeat (3) tick();
        tests_run++;
        if (out_if.tdata !== 16'h8888 || out_if.tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_new_sw3: got %h last=%b expected 8888 last=1",
                     out_if.tdata, out_if.tlast);
        end
        tick();
    endtask

    initial begin
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tstrb   = '0;
        in_if.tkeep   = '0;
        in_if.tlast   = 1'b0;
        in_if.tuser   = '0;
        in_if.tdest   = '0;
        in_if.tid     = '0;
        out_if.tready = 1'b0;
        test_reset();
        test_width();
        test_trailing();
        test_mid_null();
        test_all_zero_keep();
        test_backpressure();
        test_reset_mid_beat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
